// File: rtl/div_iterative_if.sv
// Request/response bundle between the pipeline and the iterative divider.
interface div_iterative_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_signed;
    logic             op_rem;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op_signed, op_rem, dividend, divisor,
        input  busy, valid, result
    );

    modport slave (
        input  start, op_signed, op_rem, dividend, divisor,
        output busy, valid, result
    );
endinterface

// File: rtl/div_iterative.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// operands held as magnitudes, signs applied in a final fix-up cycle.
//
// state | meaning
// IDLE  | waiting for start; busy low
// CALC  | one trial subtraction per clock, WIDTH iterations
// FIX   | sign/div-by-zero correction, result registered, valid pulses next
module div_iterative #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    div_iterative_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic [CW-1:0]    cnt;
    logic             op_rem;
    logic             quot_neg;
    logic             rem_neg;
    logic             div0;
    logic             valid;
    logic [WIDTH-1:0] result;

    logic             dvd_neg_in;
    logic             dvs_neg_in;
    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic [WIDTH:0]   pr;
    logic             borrow;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign bus.busy   = (state != IDLE);
    assign bus.valid  = valid;
    assign bus.result = result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = CALC;
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dvd_neg_in = bus.op_signed & bus.dividend[WIDTH-1];
        dvs_neg_in = bus.op_signed & bus.divisor[WIDTH-1];
        dvd_mag_in = dvd_neg_in ? -bus.dividend : bus.dividend;
        dvs_mag_in = dvs_neg_in ? -bus.divisor : bus.divisor;
    end

    // rem < divisor always holds, so a non-borrowing difference fits in WIDTH bits.
    always_comb begin
        pr     = {rem, quo[WIDTH-1]};
        borrow = (pr < {1'b0, dvs_mag});
        diff   = pr[WIDTH-1:0] - dvs_mag;
    end

    // With a zero divisor the shift loop leaves rem = |dividend|, so re-applying
    // the dividend sign restores the original dividend.
    always_comb begin
        quot_fix = div0 ? '1 : (quot_neg ? -quo : quo);
        rem_fix  = rem_neg ? -rem : rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            quo      <= '0;
            dvs_mag  <= '0;
            cnt      <= '0;
            op_rem   <= 1'b0;
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            div0     <= 1'b0;
            valid    <= 1'b0;
            result   <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rem      <= '0;
                        quo      <= dvd_mag_in;
                        dvs_mag  <= dvs_mag_in;
                        cnt      <= CW'(WIDTH - 1);
                        op_rem   <= bus.op_rem;
                        quot_neg <= dvd_neg_in ^ dvs_neg_in;
                        rem_neg  <= dvd_neg_in;
                        div0     <= (bus.divisor == '0);
                    end
                end
                CALC: begin
                    rem <= borrow ? pr[WIDTH-1:0] : diff;
                    quo <= {quo[WIDTH-2:0], ~borrow};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    result <= op_rem ? rem_fix : quot_fix;
                    valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iterative.sv
// Directed vector bench for div_iterative: results, latency, busy/start rules, reset abort.
module tb_div_iterative;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk;
    logic rst_n;

    div_iterative_if #(.WIDTH(W)) bus_if ();

    div_iterative #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic        rm;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_start(input logic sgn, input logic rm,
                               input logic [31:0] dvd, input logic [31:0] dvs);
        bus_if.op_signed = sgn;
        bus_if.op_rem    = rm;
        bus_if.dividend  = dvd;
        bus_if.divisor   = dvs;
        bus_if.start     = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start     = 1'b0;
        // scramble inputs: the in-flight op must not see them
        bus_if.op_signed = ~sgn;
        bus_if.op_rem    = ~rm;
        bus_if.dividend  = $urandom;
        bus_if.divisor   = $urandom;
    endtask

    task automatic issue(input logic sgn, input logic rm,
                         input logic [31:0] dvd, input logic [31:0] dvs);
        int guard;
        guard = 0;
        while (bus_if.busy && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        @(negedge clk);
        drive_start(sgn, rm, dvd, dvs);
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (bus_if.valid) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        issue(v.sgn, v.rm, v.dvd, v.dvs);
        check({"busy_", v.name}, 32'(bus_if.busy), 32'd1);
        wait_valid(n);
        check({"lat_", v.name}, 32'(n), 32'(LAT));
        check({"res_", v.name}, bus_if.result, v.exp);
    endtask

    initial begin
        int nv;
        int first;
        int n;
        logic [31:0] res;

        vecs[0]  = '{1'b0, 1'b0, 32'd100,       32'd7,          32'd14,         "divu_100_7"};
        vecs[1]  = '{1'b0, 1'b1, 32'd100,       32'd7,          32'd2,          "remu_100_7"};
        vecs[2]  = '{1'b1, 1'b1, -32'sd7,       32'd2,          32'hFFFFFFFF,   "rem_m7_2"};
        vecs[3]  = '{1'b1, 1'b0, -32'sd7,       32'd2,          32'hFFFFFFFD,   "div_m7_2"};
        vecs[4]  = '{1'b1, 1'b0, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   "div_ovf"};
        vecs[5]  = '{1'b1, 1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h00000000,   "rem_ovf"};
        vecs[6]  = '{1'b0, 1'b0, 32'hDEADBEEF,  32'd0,          32'hFFFFFFFF,   "divu_x_0"};
        vecs[7]  = '{1'b1, 1'b1, 32'h12345678,  32'd0,          32'h12345678,   "rem_x_0"};
        vecs[8]  = '{1'b1, 1'b0, -32'sd5,       32'd0,          32'hFFFFFFFF,   "div_m5_0"};
        vecs[9]  = '{1'b1, 1'b1, -32'sd5,       32'd0,          32'hFFFFFFFB,   "rem_m5_0"};
        vecs[10] = '{1'b1, 1'b0, 32'd7,         -32'sd2,        32'hFFFFFFFD,   "div_7_m2"};
        vecs[11] = '{1'b1, 1'b1, 32'd7,         -32'sd2,        32'd1,          "rem_7_m2"};
        vecs[12] = '{1'b0, 1'b0, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,   "divu_max_1"};
        vecs[13] = '{1'b0, 1'b0, 32'h80000000,  32'hFFFFFFFF,   32'd0,          "divu_big"};
        vecs[14] = '{1'b0, 1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   "remu_big"};
        vecs[15] = '{1'b1, 1'b1, -32'sd100,     -32'sd7,        32'hFFFFFFFE,   "rem_m100_m7"};

        rst_n            = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.op_signed = 1'b0;
        bus_if.op_rem    = 1'b0;
        bus_if.dividend  = '0;
        bus_if.divisor   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy",   32'(bus_if.busy),  32'd0);
        check("rst_valid",  32'(bus_if.valid), 32'd0);
        check("rst_result", bus_if.result,     32'd0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // start pulses while busy must be ignored
        issue(1'b0, 1'b0, 32'd1000, 32'd10);
        nv = 0;
        first = 0;
        res = '0;
        for (int c = 1; c <= 70; c++) begin
            if (c == 5 || c == 20) begin
                bus_if.op_signed = 1'b0;
                bus_if.op_rem    = 1'b1;
                bus_if.dividend  = 32'd123;
                bus_if.divisor   = 32'd0;
                bus_if.start     = 1'b1;
            end
            @(posedge clk);
            #1;
            bus_if.start = 1'b0;
            if (bus_if.valid) begin
                nv++;
                if (first == 0) begin
                    first = c;
                    res = bus_if.result;
                end
            end
        end
        check("busy_ign_count", 32'(nv),    32'd1);
        check("busy_ign_lat",   32'(first), 32'(LAT));
        check("busy_ign_res",   res,        32'd100);

        // start asserted in the valid cycle is accepted immediately
        issue(1'b0, 1'b0, 32'd500, 32'd4);
        wait_valid(n);
        check("b2b_lat1", 32'(n), 32'(LAT));
        check("b2b_res1", bus_if.result, 32'd125);
        drive_start(1'b1, 1'b0, -32'sd9, 32'd2);
        check("b2b_busy2", 32'(bus_if.busy), 32'd1);
        wait_valid(n);
        check("b2b_lat2", 32'(n), 32'(LAT));
        check("b2b_res2", bus_if.result, 32'hFFFFFFFC);

        // async reset in the middle of an operation
        issue(1'b0, 1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(bus_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",   32'(bus_if.busy),  32'd0);
        check("mid_rst_valid",  32'(bus_if.valid), 32'd0);
        check("mid_rst_result", bus_if.result,     32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus_if.valid) nv++;
        end
        check("no_stray_valid", 32'(nv), 32'd0);
        run_vec('{1'b0, 1'b0, 32'd1000, 32'd3, 32'd333, "post_rst_divu"});
        run_vec('{1'b0, 1'b1, 32'd1000, 32'd3, 32'd1,   "post_rst_remu"});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
